// File: rtl/imem_bridge_pkg.sv
// imem_bridge_pkg: shared state encoding, default fault instruction and hold-buffer record
// for the instruction memory bridge.
package imem_bridge_pkg;
   typedef logic [1:0] imem_state_t;
   localparam imem_state_t S_IDLE  = 2'd0;
   localparam imem_state_t S_WAIT  = 2'd1;
   localparam imem_state_t S_DRAIN = 2'd2;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] data;
   } imem_buf_t;
endpackage

// File: rtl/imem_hold_buf.sv
// imem_hold_buf: single-entry instruction hold buffer with lookup, fill and invalidate.
module imem_hold_buf
   import imem_bridge_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [29:0] tag,
   output logic        hit,
   output logic [31:0] data,
   input  logic        fill,
   input  logic [29:0] fill_tag,
   input  logic [31:0] fill_data,
   input  logic        inval
);
   imem_buf_t b_q;
   // invalidate wins over a same-cycle fill so a fence.i is never undone
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) b_q <= '0;
      else if (inval) b_q.valid <= 1'b0;
      else if (fill) b_q <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
   end
   assign hit  = b_q.valid && b_q.tag == tag;
   assign data = b_q.data;
endmodule

// File: rtl/imem_bridge.sv
// imem_bridge: fetch-side instruction memory responder over a single-beat stb/ack bus.
// Define IMEM_HOLD_BUF_EN to build the hold buffer; otherwise every aligned fetch goes to the bus.
module imem_bridge
   import imem_bridge_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NOP_INSTR      = DEF_NOP_INSTR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [31:0] mem_addr_i,
   input  logic        flush_i,
   input  logic        inval_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        fault_o,
   output logic        busy_o,
   output logic        bus_stb_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_ack_i,
   input  logic        bus_err_i,
   input  logic [31:0] bus_rdata_i
);
   imem_state_t state_q, state_d;
   logic [7:0]  cnt_q;
   logic [29:0] addr_q;
   logic        idle, misal, tmo, done, hit, rvalid_d, fault_d;
   logic [31:0] buf_data, rdata_d;

   assign idle       = state_q == S_IDLE;
   assign misal      = mem_addr_i[1:0] != 2'b00;
   assign tmo        = cnt_q == 8'(TIMEOUT_CYCLES);
   assign done       = !idle && (bus_ack_i || bus_err_i || tmo);
   assign busy_o     = !idle;
   assign bus_stb_o  = !idle;
   assign bus_addr_o = {addr_q, 2'b00};

`ifdef IMEM_HOLD_BUF_EN
   logic fill;
   // DRAIN acks still fill: the fetched word is good even though this response is dropped
   assign fill = !idle && bus_ack_i && !bus_err_i;
   imem_hold_buf u_buf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tag       (mem_addr_i[31:2]),
      .hit       (hit),
      .data      (buf_data),
      .fill      (fill),
      .fill_tag  (addr_q),
      .fill_data (bus_rdata_i),
      .inval     (inval_i)
   );
`else
   logic unused_inval;
   assign unused_inval = inval_i;
   assign hit          = 1'b0;
   assign buf_data     = '0;
`endif

   assign state_d  = idle ? ((req_i && !misal && !hit) ? S_WAIT : S_IDLE)
                   : done ? S_IDLE : flush_i ? S_DRAIN : state_q;
   assign rvalid_d = !flush_i && (idle ? req_i && (misal || hit) : state_q == S_WAIT && done);
   assign fault_d  = idle ? misal : (bus_err_i || !bus_ack_i);
   assign rdata_d  = fault_d ? NOP_INSTR : idle ? buf_data : bus_rdata_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         fault_o  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= idle ? 8'd0 : cnt_q + 8'd1;
         rvalid_o <= rvalid_d;
         if (idle && state_d == S_WAIT) addr_q <= mem_addr_i[31:2];
         if (rvalid_d) begin
            rdata_o <= rdata_d;
            fault_o <= fault_d;
         end
      end
   end
endmodule

// File: tb/tb_imem_bridge.sv
// tb_imem_bridge: directed vector table plus hand-written invalidate and async-reset sequences.
module tb_imem_bridge;
`ifdef IMEM_HOLD_BUF_EN
   localparam bit H = 1'b1;
`else
   localparam bit H = 1'b0;
`endif
   localparam bit O = 1'b1, Z = 1'b0;
   localparam logic [31:0] D = 32'hDEAD_BEEF, N = 32'h0000_0013;

   logic clk_i = 1'b0, rst_i = 1'b1, req_i = 1'b0, flush_i = 1'b0, inval_i = 1'b0;
   logic bus_ack_i = 1'b0, bus_err_i = 1'b0;
   logic [31:0] mem_addr_i = '0, bus_rdata_i = '0;
   logic rvalid_o, fault_o, busy_o, bus_stb_o;
   logic [31:0] rdata_o, bus_addr_o;
   int checks = 0, errors = 0;
   logic [31:0] exp_addr = '0;

   always #5 clk_i = ~clk_i;

   imem_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .mem_addr_i(mem_addr_i),
      .flush_i(flush_i), .inval_i(inval_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .fault_o(fault_o), .busy_o(busy_o), .bus_stb_o(bus_stb_o), .bus_addr_o(bus_addr_o),
      .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i)
   );

   typedef struct {
      bit req; logic [31:0] addr; bit flush, ack, err; logic [31:0] brd;
      bit rv; logic [31:0] rd; bit f, b;
   } vec_t;
   vec_t v[29];

   function automatic vec_t mk(bit req, logic [31:0] addr, bit flush, bit ack, bit err,
                               logic [31:0] brd, bit rv, logic [31:0] rd, bit f, bit b);
      mk = '{req, addr, flush, ack, err, brd, rv, rd, f, b};
   endfunction

   task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, got, exp);
      end
   endtask

   task automatic drive(bit req, logic [31:0] addr, bit flush, bit inval, bit ack, bit err,
                        logic [31:0] brd);
      req_i = req; mem_addr_i = addr; flush_i = flush; inval_i = inval;
      bus_ack_i = ack; bus_err_i = err; bus_rdata_i = brd;
      @(posedge clk_i);
      #1;
      req_i = 1'b0; mem_addr_i = '0; flush_i = 1'b0; inval_i = 1'b0;
      bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
   endtask

   task automatic expect_out(string n, bit rv, logic [31:0] rd, bit f, bit b);
      chk({n, " rvalid"}, 32'(rvalid_o), 32'(rv));
      chk({n, " rdata"}, rdata_o, rd);
      chk({n, " fault"}, 32'(fault_o), 32'(f));
      chk({n, " busy"}, 32'(busy_o), 32'(b));
      chk({n, " stb"}, 32'(bus_stb_o), 32'(b));
      if (b) chk({n, " bus_addr"}, bus_addr_o, exp_addr);
   endtask

   initial begin
      // miss then hit on 0x100
      v[0]  = mk(O, 32'h100, Z, Z, Z, 0, Z, 0, Z, O);
      v[1]  = mk(Z, 0, Z, O, Z, D, O, D, Z, Z);
      v[2]  = mk(O, 32'h100, Z, Z, Z, 0, H, D, Z, !H);
      v[3]  = mk(Z, 0, Z, O, Z, D, !H, D, Z, Z);
      // error (with ack) on the 3rd stb cycle, then the same address must miss
      v[4]  = mk(O, 32'h300, Z, Z, Z, 0, Z, D, Z, O);
      v[5]  = mk(Z, 0, Z, Z, Z, 0, Z, D, Z, O);
      v[6]  = mk(Z, 0, Z, Z, Z, 0, Z, D, Z, O);
      v[7]  = mk(Z, 0, Z, O, O, 32'h1111_1111, O, N, O, Z);
      v[8]  = mk(O, 32'h300, Z, Z, Z, 0, Z, N, O, O);
      v[9]  = mk(Z, 0, Z, O, Z, 32'h3030_3030, O, 32'h3030_3030, Z, Z);
      // timeout of 4: fault 5 cycles after stb rises
      v[10] = mk(O, 32'h400, Z, Z, Z, 0, Z, 32'h3030_3030, Z, O);
      v[11] = mk(Z, 0, Z, Z, Z, 0, Z, 32'h3030_3030, Z, O);
      v[12] = mk(Z, 0, Z, Z, Z, 0, Z, 32'h3030_3030, Z, O);
      v[13] = mk(Z, 0, Z, Z, Z, 0, Z, 32'h3030_3030, Z, O);
      v[14] = mk(Z, 0, Z, Z, Z, 0, Z, 32'h3030_3030, Z, O);
      v[15] = mk(Z, 0, Z, Z, Z, 0, O, N, O, Z);
      v[16] = mk(O, 32'h500, Z, Z, Z, 0, Z, N, O, O);
      v[17] = mk(Z, 0, Z, O, Z, 32'h5555_5555, O, 32'h5555_5555, Z, Z);
      // misaligned
      v[18] = mk(O, 32'h102, Z, Z, Z, 0, O, N, O, Z);
      v[19] = mk(Z, 0, Z, Z, Z, 0, Z, N, O, Z);
      // flush on 2nd stb cycle, ack two cycles later, then re-request
      v[20] = mk(O, 32'h600, Z, Z, Z, 0, Z, N, O, O);
      v[21] = mk(Z, 0, Z, Z, Z, 0, Z, N, O, O);
      v[22] = mk(Z, 0, O, Z, Z, 0, Z, N, O, O);
      v[23] = mk(Z, 0, Z, Z, Z, 0, Z, N, O, O);
      v[24] = mk(Z, 0, Z, O, Z, 32'h6666_6666, Z, N, O, Z);
      v[25] = mk(O, 32'h600, Z, Z, Z, 0, H, H ? 32'h6666_6666 : N, !H, !H);
      v[26] = mk(Z, 0, Z, O, Z, 32'h6666_6666, !H, 32'h6666_6666, Z, Z);
      // flush in IDLE suppresses a hit response
      v[27] = mk(O, 32'h600, O, Z, Z, 0, Z, 32'h6666_6666, Z, !H);
      v[28] = mk(Z, 0, Z, O, Z, 32'h6666_6666, !H, 32'h6666_6666, Z, Z);

      repeat (2) @(posedge clk_i);
      #1;
      expect_out("reset", Z, 0, Z, Z);
      chk("reset bus_addr", bus_addr_o, 0);
      rst_i = 1'b0;

      for (int i = 0; i < 29; i++) begin
         if (v[i].req) exp_addr = {v[i].addr[31:2], 2'b00};
         drive(v[i].req, v[i].addr, v[i].flush, Z, v[i].ack, v[i].err, v[i].brd);
         expect_out($sformatf("vec%0d", i), v[i].rv, v[i].rd, v[i].f, v[i].b);
      end

      // fill 0x200, invalidate, re-request must go to the bus
      exp_addr = 32'h200;
      drive(O, 32'h200, Z, Z, Z, Z, 0);
      expect_out("inv fill req", Z, 32'h6666_6666, Z, O);
      drive(Z, 0, Z, Z, O, Z, 32'h2222_2222);
      expect_out("inv fill ack", O, 32'h2222_2222, Z, Z);
      drive(Z, 0, Z, O, Z, Z, 0);
      expect_out("inv pulse", Z, 32'h2222_2222, Z, Z);
      drive(O, 32'h200, Z, Z, Z, Z, 0);
      expect_out("inv rereq", Z, 32'h2222_2222, Z, O);
      drive(Z, 0, Z, Z, O, Z, 32'h2222_2222);
      expect_out("inv reack", O, 32'h2222_2222, Z, Z);

      // invalidate coinciding with the ack: data returned, buffer not filled
      exp_addr = 32'h700;
      drive(O, 32'h700, Z, Z, Z, Z, 0);
      expect_out("invfill req", Z, 32'h2222_2222, Z, O);
      drive(Z, 0, Z, O, O, Z, 32'h7777_7777);
      expect_out("invfill ack", O, 32'h7777_7777, Z, Z);
      drive(O, 32'h700, Z, Z, Z, Z, 0);
      expect_out("invfill rereq", Z, 32'h7777_7777, Z, O);
      drive(Z, 0, Z, Z, O, Z, 32'h7070_7070);
      expect_out("invfill reack", O, 32'h7070_7070, Z, Z);

      // async reset mid-WAIT, then the buffered 0x200 must miss
      exp_addr = 32'h800;
      drive(O, 32'h800, Z, Z, Z, Z, 0);
      expect_out("rst req", Z, 32'h7070_7070, Z, O);
      #2;
      rst_i = 1'b1;
      #1;
      chk("async rst stb", 32'(bus_stb_o), 0);
      chk("async rst busy", 32'(busy_o), 0);
      chk("async rst rvalid", 32'(rvalid_o), 0);
      chk("async rst rdata", rdata_o, 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      exp_addr = 32'h200;
      drive(O, 32'h200, Z, Z, Z, Z, 0);
      expect_out("post rst req", Z, 0, Z, O);
      drive(Z, 0, Z, Z, O, Z, 32'h2222_2222);
      expect_out("post rst ack", O, 32'h2222_2222, Z, Z);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_bridge.md
# imem_bridge

Instruction-side responder for the fetch stage's read-only memory interface. It accepts the word address fetch presents each cycle, returns the instruction one cycle later when the address hits its single-entry hold buffer, and otherwise runs a single-beat request/acknowledge transaction on the external instruction bus. While a transaction is outstanding it raises a busy indication to the hazard/stall logic. It sits between the core's fetch stage and the SoC instruction bus.

## Interface
- TIMEOUT_CYCLES, 255: bus wait cycles before an access is declared faulted; range 1..255.
- NOP_INSTR, 32'h0000_0013: instruction word returned with a fault.
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- req_i  input  1  fetch requests the word at mem_addr_i; sampled only in IDLE
- mem_addr_i  input  32  fetch address (pc)
- flush_i  input  1  squash: discard the in-flight or next-cycle response
- inval_i  input  1  invalidate hold buffer (fence.i)
- rvalid_o  output  1  rdata_o/fault_o valid; one-cycle pulse per accepted request
- rdata_o  output  32  instruction word
- fault_o  output  1  instruction access fault (misaligned, bus error or timeout)
- busy_o  output  1  transaction outstanding; hazard unit stalls fetch
- bus_stb_o  output  1  bus request strobe
- bus_addr_o  output  32  bus word address, bits [1:0] = 0
- bus_ack_i  input  1  bus read complete
- bus_err_i  input  1  bus error
- bus_rdata_i  input  32  bus read data

## Operation
- States: IDLE, WAIT, DRAIN; busy_o = (state != IDLE), decoded from the state register.
- IDLE, req_i=1:
  - If mem_addr_i[1:0] != 0: no bus access; next cycle rvalid_o=1, fault_o=1, rdata_o=NOP_INSTR.
  - If buffer hit (buf_valid && buf_tag == mem_addr_i[31:2]): next cycle rvalid_o=1, rdata_o=buffer data, fault_o=0.
  - Otherwise: latch the address and go to WAIT. Clear the timeout counter.
- WAIT:
  - bus_stb_o=1 and bus_addr_o holds the latched address.
  - The counter increments each cycle.
  - On bus_ack_i: fill the buffer (tag and data); next cycle rvalid_o=1 with the data; go to IDLE.
  - On bus_err_i, or when the counter reaches TIMEOUT_CYCLES: next cycle rvalid_o=1, fault_o=1, rdata_o=NOP_INSTR; the buffer is not filled; go to IDLE.
  - If bus_ack_i and bus_err_i are both high, bus_err_i wins.
- flush_i:
  - In IDLE: suppresses the rvalid_o that would follow this cycle's request.
  - In WAIT with no ack/err/timeout that cycle: go to DRAIN.
  - In WAIT with ack/err/timeout the same cycle: go to IDLE, and rvalid_o is not raised.
- DRAIN: bus_stb_o stays high until ack, err or timeout. The result is discarded, except that an ack still fills the buffer. Then go to IDLE with no rvalid_o.
- inval_i: clears buf_valid at the clock edge. It takes priority over a same-cycle fill; the data is still returned, but the buffer is not filled.
- Reset values: state=IDLE, rvalid_o=0, rdata_o=0, fault_o=0, busy_o=0, bus_stb_o=0, bus_addr_o=0, buf_valid=0, counter=0.

## Timing
- Hit or misaligned latency: rvalid_o is high 1 cycle after the req_i cycle.
- Miss latency: bus_stb_o rises 1 cycle after req_i. rvalid_o is high 1 cycle after the ack/err cycle.
  - Minimum miss latency, with ack in the first stb cycle: 2 cycles.
- Timeout: with no response, fault_o/rvalid_o appear TIMEOUT_CYCLES+1 cycles after the first stb cycle.
- busy_o is high from the cycle after a miss request through the ack cycle. It is low in the cycle rvalid_o is high, so fetch can present the next address in that cycle.
- rvalid_o is a single-cycle pulse. rdata_o and fault_o hold their last values afterwards.
- Reset asserted mid-transaction: bus_stb_o drops asynchronously. The bus must tolerate an abandoned strobe.
- req_i is ignored whenever busy_o is high.

## Configuration
- IMEM_HOLD_BUF_EN defined:
  - The single-entry hold buffer (tag 30 bits, data 32 bits, valid) is built.
  - Hits return in 1 cycle with no bus traffic.
- IMEM_HOLD_BUF_EN undefined:
  - No buffer is built; every aligned request is a miss.
  - inval_i is ignored.
  - The fill logic is removed.

## Structure
- Shared package (defs.svh):
  - imem_state_t enum {IDLE, WAIT, DRAIN}
  - NOP_INSTR default constant
  - typedef imem_buf_t {valid, tag[29:0], data[31:0]}
- One sub-module, imem_hold_buf: the tag/data/valid register with lookup, fill and invalidate. It is instantiated only under IMEM_HOLD_BUF_EN.

## Test plan
- Miss then hit:
  - req 0x100, ack in the 1st stb cycle with 0xDEADBEEF: rvalid with 0xDEADBEEF 2 cycles after req.
  - Re-req 0x100: rvalid 1 cycle later, no bus_stb_o.
- Misaligned: req 0x102 gives rvalid, fault_o=1, rdata=0x00000013 next cycle, with no bus_stb_o.
- Bus error and timeout:
  - bus_err_i on the 3rd stb cycle gives a fault pulse, and the buffer is unchanged (a re-req misses).
  - With TIMEOUT_CYCLES=4 and no ack, fault appears 5 cycles after stb rises.
- Flush in WAIT: flush on the 2nd stb cycle, ack 2 cycles later.
  - State goes to DRAIN, busy_o stays high until the ack, and no rvalid_o is raised.
  - A re-req to the same address then hits.
- Invalidate: fill 0x200, then pulse inval_i; re-req 0x200 issues a bus access.
- Async reset mid-WAIT: bus_stb_o, busy_o and rvalid_o go to 0 immediately. The first req after reset misses.
